// File: rtl/program_memory_loader_if.sv
// program_memory_loader_if: fetch port and byte-stream loader port of the program memory.
interface program_memory_loader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   logic                  fetch_en;
   logic [ADDR_WIDTH-1:0] fetch_address;
   logic [DATA_WIDTH-1:0] fetch_data;
   logic                  fetch_valid;
   logic                  fetch_fault;
   logic                  load_start;
   logic [ADDR_WIDTH-1:0] load_base;
   logic [ADDR_WIDTH-1:0] load_count;
   logic [7:0]            load_byte;
   logic                  load_byte_valid;
   logic                  load_ready;
   logic                  load_busy;
   logic                  load_done;
   logic                  load_error;
   modport master (
      output fetch_en, fetch_address, load_start, load_base, load_count, load_byte, load_byte_valid,
      input  fetch_data, fetch_valid, fetch_fault, load_ready, load_busy, load_done, load_error
   );
   modport slave (
      input  fetch_en, fetch_address, load_start, load_base, load_count, load_byte, load_byte_valid,
      output fetch_data, fetch_valid, fetch_fault, load_ready, load_busy, load_done, load_error
   );
endinterface

// File: rtl/program_memory_loader.sv
// program_memory_loader: instruction RAM with a registered fetch port and a byte-serial
// loader that packs big-endian bytes into words and writes them from a base address.
module program_memory_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 20000
)(
   input  logic clk,
   input  logic rst_n,
   program_memory_loader_if.slave bus
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int CW    = $clog2(BYTES + 1);
   localparam int MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH + 1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
   state_t                r_state, w_next;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] r_fetch_data;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [ADDR_WIDTH-1:0] r_remaining;
   logic [CW-1:0]         r_cnt;
   logic                  r_fetch_valid;
   logic                  r_fetch_fault;
   logic                  r_load_done;
   logic                  r_load_error;
   logic                  w_fetch;
   logic                  w_rd_ok;
   logic                  w_wr_ok;
   logic                  w_byte;
   logic                  w_last;
   logic                  w_we;
   assign w_fetch = bus.fetch_en && (r_state == IDLE);
   assign w_rd_ok = {1'b0, bus.fetch_address} < LIM;
   assign w_wr_ok = {1'b0, r_wr_addr} < LIM;
   assign w_byte  = (r_state == RECV) && bus.load_byte_valid;
   assign w_last  = w_byte && (r_cnt == CW'(BYTES - 1));
   assign w_we    = (r_state == WRITE) && w_wr_ok;
   assign bus.fetch_data  = r_fetch_data;
   assign bus.fetch_valid = r_fetch_valid;
   assign bus.fetch_fault = r_fetch_fault;
   assign bus.load_ready  = (r_state == RECV);
   assign bus.load_busy   = (r_state != IDLE);
   assign bus.load_done   = r_load_done;
   assign bus.load_error  = r_load_error;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = bus.load_start ? ((bus.load_count == '0) ? DONE : RECV) : IDLE;
         RECV:    w_next = w_last ? WRITE : RECV;
         WRITE:   w_next = (r_remaining == ADDR_WIDTH'(1)) ? DONE : RECV;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   // Memory has no reset so a reset mid-load keeps the words already written.
   always_ff @(posedge clk)
      if (w_we) r_mem[r_wr_addr[MW-1:0]] <= r_shift;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_fetch_data  <= '0;
         r_fetch_valid <= 1'b0;
         r_fetch_fault <= 1'b0;
         r_load_done   <= 1'b0;
         r_load_error  <= 1'b0;
         r_wr_addr     <= '0;
         r_remaining   <= '0;
         r_shift       <= '0;
         r_cnt         <= '0;
      end else begin
         r_fetch_valid <= w_fetch;
         r_load_done   <= (r_state == DONE);
         if (w_fetch) begin
            r_fetch_data  <= w_rd_ok ? r_mem[bus.fetch_address[MW-1:0]] : '0;
            r_fetch_fault <= !w_rd_ok;
         end
         if ((r_state == IDLE) && bus.load_start) begin
            r_wr_addr    <= bus.load_base;
            r_remaining  <= bus.load_count;
            r_load_error <= 1'b0;
         end
         if (w_byte) begin
            r_shift <= (r_shift << 8) | DATA_WIDTH'(bus.load_byte);
            r_cnt   <= r_cnt + CW'(1);
         end
         if (r_state == WRITE) begin
            r_cnt       <= '0;
            r_wr_addr   <= r_wr_addr + ADDR_WIDTH'(1);
            r_remaining <= r_remaining - ADDR_WIDTH'(1);
            if (!w_wr_ok) r_load_error <= 1'b1;
         end
      end
endmodule

// File: tb/tb_program_memory_loader.sv
// tb_program_memory_loader: table-driven fetch vectors, hand-written load/reset sequences and
// randomized loads checked against an array model of the memory and the error flag.
module tb_program_memory_loader;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam int DEPTH = 20000;
   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
      logic        fault;
   } fvec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [31:0] ref_mem [DEPTH];
   bit known [DEPTH];
   logic [7:0] byte_q [$];
   logic [15:0] addr_q [$];
   fvec_t fv [6];
   always #5 clk = ~clk;
   program_memory_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
   program_memory_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask
   task automatic idle_inputs();
      bus.fetch_en = 0; bus.fetch_address = '0; bus.load_start = 0; bus.load_base = '0;
      bus.load_count = '0; bus.load_byte = '0; bus.load_byte_valid = 0;
   endtask
   function automatic logic [63:0] all_outs();
      return {26'd0, bus.fetch_data, bus.fetch_valid, bus.fetch_fault, bus.load_ready,
              bus.load_busy, bus.load_done, bus.load_error};
   endfunction
   task automatic fetch_chk(input logic [15:0] a, input logic [31:0] exp_d, input logic exp_f, input bit chk_d);
      bus.fetch_en = 1; bus.fetch_address = a;
      @(negedge clk);
      bus.fetch_en = 0; bus.fetch_address = 16'($urandom);
      check("fetch_valid", bus.fetch_valid, 1);
      check("fetch_fault", bus.fetch_fault, exp_f);
      if (chk_d) check("fetch_data", bus.fetch_data, exp_d);
      @(negedge clk);
      check("fetch_valid_low", bus.fetch_valid, 0);
      check("fetch_fault_hold", bus.fetch_fault, exp_f);
      if (chk_d) check("fetch_data_hold", bus.fetch_data, exp_d);
   endtask
   task automatic fetch_ref(input logic [15:0] a);
      if (a < DEPTH) fetch_chk(a, ref_mem[a], 1'b0, known[a]);
      else fetch_chk(a, 32'd0, 1'b1, 1'b1);
   endtask
   // Feeds byte_q[0..n-1], honouring load_ready; also tries fetches and stray bytes while busy.
   task automatic feed(input int n);
      int idx = 0;
      int guard = 0;
      bit pend = 0;
      while (idx < n && guard < 5000) begin
         if (pend) check("fetch_blocked_busy", bus.fetch_valid, 0);
         pend = 0;
         bus.fetch_en = 0;
         if (bus.load_ready) begin
            bus.load_byte_valid = ($urandom % 4 != 0);
            bus.load_byte = bus.load_byte_valid ? byte_q[idx] : 8'($urandom);
            if (bus.load_byte_valid) idx++;
         end else begin
            bus.load_byte_valid = 1'($urandom);
            bus.load_byte = 8'($urandom);
         end
         if (bus.load_busy && (guard == 0 || $urandom % 4 == 0)) begin
            bus.fetch_en = 1; bus.fetch_address = 16'($urandom_range(0, 40));
            pend = 1;
         end
         @(negedge clk);
         guard++;
      end
      if (pend) check("fetch_blocked_busy", bus.fetch_valid, 0);
      bus.fetch_en = 0; bus.load_byte_valid = 0;
      if (idx < n) check("feed_timeout", idx, n);
   endtask
   task automatic do_load(input logic [15:0] base, input logic [15:0] cnt);
      logic exp_err = 0;
      logic [15:0] a;
      int guard = 0;
      for (int k = 0; k < int'(cnt); k++) begin
         a = base + 16'(k);
         addr_q.push_back(a);
         if (a < DEPTH) begin
            ref_mem[a] = {byte_q[4*k], byte_q[4*k+1], byte_q[4*k+2], byte_q[4*k+3]};
            known[a] = 1;
         end else exp_err = 1;
      end
      bus.load_start = 1; bus.load_base = base; bus.load_count = cnt;
      @(negedge clk);
      bus.load_start = 0; bus.load_base = 16'($urandom); bus.load_count = 16'($urandom);
      feed(4 * int'(cnt));
      while (!bus.load_done && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("load_done", bus.load_done, 1);
      check("load_error", bus.load_error, exp_err);
      check("load_busy_end", bus.load_busy, 0);
      @(negedge clk);
      check("load_done_pulse", bus.load_done, 0);
      check("load_error_sticky", bus.load_error, exp_err);
      byte_q.delete();
   endtask
   initial begin
      logic [15:0] base;
      fv = '{'{16'h0010, 32'h12345678, 1'b0}, '{16'h0011, 32'h9ABCDEF0, 1'b0},
             '{16'hFFFF, 32'h0, 1'b1}, '{16'(DEPTH), 32'h0, 1'b1},
             '{16'(DEPTH - 1), 32'hCAFEBABE, 1'b0}, '{16'h0010, 32'h12345678, 1'b0}};
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.fetch_en = 1; bus.fetch_address = 16'($urandom); bus.load_start = 1;
         bus.load_count = 16'd3; bus.load_byte_valid = 1; bus.load_byte = 8'($urandom);
         @(negedge clk);
         check("reset_outputs", all_outs(), 64'd0);
      end
      idle_inputs();
      rst_n = 1;
      @(negedge clk);
      check("post_reset_busy", bus.load_busy, 0);
      check("post_reset_ready", bus.load_ready, 0);
      byte_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      do_load(16'h0010, 16'd2);
      byte_q = '{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      do_load(16'(DEPTH - 1), 16'd2);
      bus.load_start = 1; bus.load_base = 16'h0010; bus.load_count = 16'd0;
      @(negedge clk);
      bus.load_start = 0;
      check("cnt0_ready", bus.load_ready, 0);
      check("cnt0_busy", bus.load_busy, 1);
      check("cnt0_done_early", bus.load_done, 0);
      check("cnt0_error_cleared", bus.load_error, 0);
      @(negedge clk);
      check("cnt0_done", bus.load_done, 1);
      check("cnt0_ready2", bus.load_ready, 0);
      check("cnt0_busy2", bus.load_busy, 0);
      @(negedge clk);
      check("cnt0_done_pulse", bus.load_done, 0);
      for (int i = 0; i < 6; i++) fetch_chk(fv[i].addr, fv[i].data, fv[i].fault, 1'b1);
      byte_q = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
      do_load(16'h0000, 16'd2);
      byte_q = '{8'h33, 8'h33, 8'h33, 8'h33, 8'h44};
      bus.load_start = 1; bus.load_base = 16'h0000; bus.load_count = 16'd2;
      @(negedge clk);
      bus.load_start = 0;
      feed(5);
      byte_q.delete();
      ref_mem[0] = 32'h33333333;
      #2 rst_n = 0;
      #1 check("abort_reset_outputs", all_outs(), 64'd0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      check("abort_busy", bus.load_busy, 0);
      fetch_chk(16'h0000, 32'h33333333, 1'b0, 1'b1);
      fetch_chk(16'h0001, 32'h22222222, 1'b0, 1'b1);
      byte_q = '{8'h55, 8'h66, 8'h77, 8'h88};
      do_load(16'h0001, 16'd1);
      fetch_chk(16'h0001, 32'h55667788, 1'b0, 1'b1);
      for (int i = 0; i < 25; i++) begin
         case ($urandom % 4)
            0: base = 16'($urandom_range(0, DEPTH - 10));
            1: base = 16'($urandom_range(DEPTH - 3, DEPTH + 1));
            2: base = 16'hFFFF - 16'($urandom_range(0, 2));
            default: base = 16'($urandom_range(0, 200));
         endcase
         for (int j = 0; j < 16; j++) byte_q.push_back(8'($urandom));
         do_load(base, 16'($urandom_range(1, 4)));
      end
      for (int i = 0; i < 40; i++) begin
         if ($urandom % 5 == 0) fetch_ref(16'($urandom_range(DEPTH, 65535)));
         else fetch_ref(addr_q[$urandom % addr_q.size()]);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
